// File: rtl/erbium_stream_driver.sv
// rtl/erbium_stream_driver.sv - ERBium kernel job initiator: start pulse, NFA/query streaming, result drain, status report
// Optional watchdog abort enabled by defining ERBIUM_DRV_TIMEOUT_EN.
module erbium_stream_driver #(
   parameter int DATA_WIDTH     = 512,
   parameter int CNT_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic [31:0]             cmd_nfa_hash_i,
   input  logic [CNT_WIDTH-1:0]    cmd_nfa_beats_i,
   input  logic [CNT_WIDTH-1:0]    cmd_query_beats_i,
   input  logic                    src_valid_i,
   output logic                    src_ready_o,
   input  logic [DATA_WIDTH-1:0]   src_data_i,
   output logic                    ap_start_o,
   input  logic                    ap_done_i,
   output logic [31:0]             nfa_hash_o,
   output logic                    m_tvalid_o,
   input  logic                    m_tready_i,
   output logic [DATA_WIDTH-1:0]   m_tdata_o,
   output logic [DATA_WIDTH/8-1:0] m_tkeep_o,
   output logic                    m_tlast_o,
   input  logic                    s_tvalid_i,
   output logic                    s_tready_o,
   input  logic [DATA_WIDTH-1:0]   s_tdata_i,
   input  logic                    s_tlast_i,
   output logic                    sts_valid_o,
   output logic                    sts_err_o,
   output logic                    sts_timeout_o,
   output logic [CNT_WIDTH-1:0]    sts_result_beats_o,
   output logic [CNT_WIDTH-1:0]    sts_cycles_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_SEND_NFA,
      S_SEND_QRY,
      S_WAIT_DONE,
      S_REPORT
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t                 state_q, state_d;
   logic [31:0]            hash_q, hash_d;
   logic [31:0]            last_hash_q, last_hash_d;
   logic [CNT_WIDTH-1:0]   nfa_beats_q, nfa_beats_d;
   logic [CNT_WIDTH-1:0]   qry_beats_q, qry_beats_d;
   logic                   reload_q, reload_d;
   logic [CNT_WIDTH-1:0]   rem_q, rem_d;
   logic                   done_seen_q, done_seen_d;
   logic                   err_q, err_d;
   logic [CNT_WIDTH-1:0]   result_beats_q, result_beats_d;
   logic [CNT_WIDTH-1:0]   cycles_q, cycles_d;
   logic                   cmd_ready_q, cmd_ready_d;
   logic                   ap_start_q, ap_start_d;
   logic                   s_tready_q, s_tready_d;
   logic [31:0]            nfa_hash_q, nfa_hash_d;
   logic                   sts_valid_q, sts_valid_d;
   logic                   sts_err_q, sts_err_d;
   logic                   sts_timeout_q, sts_timeout_d;
   logic [CNT_WIDTH-1:0]   sts_result_beats_q, sts_result_beats_d;
   logic [CNT_WIDTH-1:0]   sts_cycles_q, sts_cycles_d;

   logic sending;
   logic m_hs;
   logic s_hs;
   logic cmd_hs;
   logic last_beat;
   logic in_job;
   logic timeout_hit;
   logic unused_inputs;

   // Result data is only counted, never inspected.
   assign unused_inputs = ^{s_tdata_i, s_tlast_i, (TIMEOUT_CYCLES == 0)};

   assign sending   = (state_q == S_SEND_NFA) || (state_q == S_SEND_QRY);
   assign in_job    = sending || (state_q == S_WAIT_DONE);
   assign m_hs      = sending && src_valid_i && m_tready_i;
   assign s_hs      = s_tready_q && s_tvalid_i;
   assign cmd_hs    = cmd_ready_q && cmd_valid_i;
   assign last_beat = (rem_q == CNT_ONE);

   // Payload is passed straight through from the source to the kernel while streaming.
   always_comb begin
      m_tvalid_o  = sending && src_valid_i;
      src_ready_o = sending && m_tready_i;
      m_tdata_o   = src_data_i;
      m_tlast_o   = sending && last_beat;
      m_tkeep_o   = '1;
   end

`ifdef ERBIUM_DRV_TIMEOUT_EN
   logic [CNT_WIDTH-1:0] wd_q, wd_d;

   // Watchdog fires only if a full idle window passes with no stream progress.
   assign timeout_hit = in_job && !m_hs && !s_hs
                        && (wd_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

   // Watchdog restarts on any progress or state change and counts only while the job is live.
   always_comb begin
      wd_d = wd_q;
      if ((state_d != state_q) || m_hs || s_hs) begin
         wd_d = '0;
      end else if (in_job) begin
         wd_d = wd_q + CNT_ONE;
      end
   end

   // Watchdog counter register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state and datapath computation for the whole job sequence.
   always_comb begin
      state_d            = state_q;
      hash_d             = hash_q;
      last_hash_d        = last_hash_q;
      nfa_beats_d        = nfa_beats_q;
      qry_beats_d        = qry_beats_q;
      reload_d           = reload_q;
      rem_d              = rem_q;
      done_seen_d        = done_seen_q;
      err_d              = err_q;
      result_beats_d     = result_beats_q;
      cycles_d           = cycles_q;
      nfa_hash_d         = nfa_hash_q;
      sts_err_d          = sts_err_q;
      sts_timeout_d      = sts_timeout_q;
      sts_result_beats_d = sts_result_beats_q;
      sts_cycles_d       = sts_cycles_q;

      if (s_hs && (result_beats_q != CNT_MAX)) begin
         result_beats_d = result_beats_q + CNT_ONE;
      end
      if (in_job && !done_seen_q && (cycles_q != CNT_MAX)) begin
         cycles_d = cycles_q + CNT_ONE;
      end
      if (m_hs) begin
         rem_d = rem_q - CNT_ONE;
      end

      case (state_q)
         S_IDLE: begin
            if (cmd_hs) begin
               hash_d             = cmd_nfa_hash_i;
               nfa_beats_d        = cmd_nfa_beats_i;
               qry_beats_d        = cmd_query_beats_i;
               result_beats_d     = '0;
               cycles_d           = '0;
               rem_d              = '0;
               done_seen_d        = 1'b0;
               sts_err_d          = 1'b0;
               sts_timeout_d      = 1'b0;
               sts_result_beats_d = '0;
               sts_cycles_d       = '0;
               if (cmd_query_beats_i == '0) begin
                  err_d    = 1'b1;
                  reload_d = 1'b0;
                  state_d  = S_REPORT;
               end else begin
                  err_d      = 1'b0;
                  reload_d   = (cmd_nfa_hash_i != last_hash_q) && (cmd_nfa_beats_i != '0);
                  nfa_hash_d = cmd_nfa_hash_i;
                  state_d    = S_START;
               end
            end
         end
         S_START: begin
            last_hash_d = hash_q;
            if (reload_q) begin
               rem_d   = nfa_beats_q;
               state_d = S_SEND_NFA;
            end else begin
               rem_d   = qry_beats_q;
               state_d = S_SEND_QRY;
            end
         end
         S_SEND_NFA: begin
            if (m_hs && last_beat) begin
               rem_d   = qry_beats_q;
               state_d = S_SEND_QRY;
            end
         end
         S_SEND_QRY: begin
            if (ap_done_i) begin
               done_seen_d = 1'b1;
            end
            if (m_hs && last_beat) begin
               state_d = (done_seen_q || ap_done_i) ? S_REPORT : S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (ap_done_i || done_seen_q) begin
               state_d = S_REPORT;
            end
         end
         S_REPORT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (timeout_hit) begin
         state_d       = S_REPORT;
         last_hash_d   = '0;
         sts_timeout_d = 1'b1;
      end

      // Snapshot the job results on the way into REPORT so they hold until the next command.
      if ((state_d == S_REPORT) && (state_q != S_REPORT)) begin
         sts_err_d          = err_d;
         sts_result_beats_d = result_beats_d;
         sts_cycles_d       = cycles_d;
      end
   end

   // Handshake and pulse outputs are registered from the upcoming state.
   always_comb begin
      cmd_ready_d = (state_d == S_IDLE);
      ap_start_d  = (state_d == S_START);
      s_tready_d  = (state_d != S_IDLE) && (state_d != S_REPORT);
      sts_valid_d = (state_d == S_REPORT);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q            <= S_IDLE;
         hash_q             <= '0;
         last_hash_q        <= '0;
         nfa_beats_q        <= '0;
         qry_beats_q        <= '0;
         reload_q           <= 1'b0;
         rem_q              <= '0;
         done_seen_q        <= 1'b0;
         err_q              <= 1'b0;
         result_beats_q     <= '0;
         cycles_q           <= '0;
         cmd_ready_q        <= 1'b0;
         ap_start_q         <= 1'b0;
         s_tready_q         <= 1'b0;
         nfa_hash_q         <= '0;
         sts_valid_q        <= 1'b0;
         sts_err_q          <= 1'b0;
         sts_timeout_q      <= 1'b0;
         sts_result_beats_q <= '0;
         sts_cycles_q       <= '0;
      end else begin
         state_q            <= state_d;
         hash_q             <= hash_d;
         last_hash_q        <= last_hash_d;
         nfa_beats_q        <= nfa_beats_d;
         qry_beats_q        <= qry_beats_d;
         reload_q           <= reload_d;
         rem_q              <= rem_d;
         done_seen_q        <= done_seen_d;
         err_q              <= err_d;
         result_beats_q     <= result_beats_d;
         cycles_q           <= cycles_d;
         cmd_ready_q        <= cmd_ready_d;
         ap_start_q         <= ap_start_d;
         s_tready_q         <= s_tready_d;
         nfa_hash_q         <= nfa_hash_d;
         sts_valid_q        <= sts_valid_d;
         sts_err_q          <= sts_err_d;
         sts_timeout_q      <= sts_timeout_d;
         sts_result_beats_q <= sts_result_beats_d;
         sts_cycles_q       <= sts_cycles_d;
      end
   end

   assign cmd_ready_o        = cmd_ready_q;
   assign ap_start_o         = ap_start_q;
   assign s_tready_o         = s_tready_q;
   assign nfa_hash_o         = nfa_hash_q;
   assign sts_valid_o        = sts_valid_q;
   assign sts_err_o          = sts_err_q;
   assign sts_timeout_o      = sts_timeout_q;
   assign sts_result_beats_o = sts_result_beats_q;
   assign sts_cycles_o       = sts_cycles_q;

endmodule

// File: tb/tb_erbium_stream_driver.sv
// tb/tb_erbium_stream_driver.sv - randomized self-checking bench for erbium_stream_driver
module tb_erbium_stream_driver;

   localparam int DW = 512;
   localparam int CW = 32;
`ifdef ERBIUM_DRV_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 65536;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          cmd_valid_i;
   logic          cmd_ready_o;
   logic [31:0]   cmd_nfa_hash_i;
   logic [CW-1:0] cmd_nfa_beats_i;
   logic [CW-1:0] cmd_query_beats_i;
   logic          src_valid_i;
   logic          src_ready_o;
   logic [DW-1:0] src_data_i;
   logic          ap_start_o;
   logic          ap_done_i;
   logic [31:0]   nfa_hash_o;
   logic          m_tvalid_o;
   logic          m_tready_i;
   logic [DW-1:0] m_tdata_o;
   logic [DW/8-1:0] m_tkeep_o;
   logic          m_tlast_o;
   logic          s_tvalid_i;
   logic          s_tready_o;
   logic [DW-1:0] s_tdata_i;
   logic          s_tlast_i;
   logic          sts_valid_o;
   logic          sts_err_o;
   logic          sts_timeout_o;
   logic [CW-1:0] sts_result_beats_o;
   logic [CW-1:0] sts_cycles_o;

   erbium_stream_driver #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_nfa_hash_i(cmd_nfa_hash_i), .cmd_nfa_beats_i(cmd_nfa_beats_i),
      .cmd_query_beats_i(cmd_query_beats_i),
      .src_valid_i(src_valid_i), .src_ready_o(src_ready_o), .src_data_i(src_data_i),
      .ap_start_o(ap_start_o), .ap_done_i(ap_done_i), .nfa_hash_o(nfa_hash_o),
      .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .m_tdata_o(m_tdata_o),
      .m_tkeep_o(m_tkeep_o), .m_tlast_o(m_tlast_o),
      .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o), .s_tdata_i(s_tdata_i),
      .s_tlast_i(s_tlast_i),
      .sts_valid_o(sts_valid_o), .sts_err_o(sts_err_o), .sts_timeout_o(sts_timeout_o),
      .sts_result_beats_o(sts_result_beats_o), .sts_cycles_o(sts_cycles_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;
   logic [31:0] last_hash_m = 32'h0;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
      return w;
   endfunction

   task automatic do_reset();
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      cmd_valid_i = 1'b0; src_valid_i = 1'b0; ap_done_i = 1'b0;
      m_tready_i = 1'b0; s_tvalid_i = 1'b0; s_tlast_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      last_hash_m = 32'h0;
   endtask

   // rmode: 0 ready always, 1 toggle, 2 random. vmode: 0 source always valid, 1 gaps.
   task automatic run_job(input logic [31:0] hash, input int nfa, input int qry, input int nres,
                          input int rmode, input int vmode, input bit early,
                          input bit no_done, input bit expect_to);
      bit            reload;
      int            total, nseg;
      logic [DW-1:0] beats[$];
      int            m_cnt, res_sent, starts, start_cyc, done_cyc, acc_cyc;
      bit            done_fired, got_sts, exp_last;
      logic [CW-1:0] held;

      reload = (hash != last_hash_m) && (nfa != 0);
      nseg   = reload ? nfa : 0;
      total  = (qry == 0) ? 0 : nseg + qry;
      for (int i = 0; i < total; i++) beats.push_back(rand_word());
      m_cnt = 0; res_sent = 0; starts = 0; start_cyc = -1; done_cyc = -1;
      done_fired = 1'b0; got_sts = 1'b0;

      @(posedge clk_i); #1;
      cmd_valid_i = 1'b1; cmd_nfa_hash_i = hash;
      cmd_nfa_beats_i = CW'(nfa); cmd_query_beats_i = CW'(qry);
      for (int k = 0; k < 50; k++) begin
         @(negedge clk_i);
         if (cmd_ready_o) break;
      end
      check("cmd_accept", cmd_ready_o, 1);
      acc_cyc = cyc;
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b0;
      src_valid_i = 1'b0; m_tready_i = 1'b0; s_tvalid_i = 1'b0; ap_done_i = 1'b0;

      for (int k = 0; k < 3000; k++) begin
         @(negedge clk_i);
         if (ap_start_o) begin
            starts++;
            start_cyc = cyc;
            check("start_hash", nfa_hash_o, hash);
         end
         if (m_tvalid_o && m_tready_i) begin
            if (m_cnt < total) begin
               exp_last = (m_cnt == total - 1) || (reload && (m_cnt == nfa - 1));
               check("m_data", m_tdata_o, beats[m_cnt]);
               check("m_tlast", m_tlast_o, exp_last);
               check("src_ready", src_ready_o, 1);
            end else begin
               check("m_extra_beat", m_cnt, total - 1);
            end
            m_cnt++;
         end
         if (s_tvalid_i && s_tready_o) res_sent++;
         if (ap_done_i) done_cyc = cyc;
         if (sts_valid_o) begin
            got_sts = 1'b1;
            break;
         end
         @(posedge clk_i); #1;
         src_valid_i = (m_cnt < total) && ((vmode == 0) || ($urandom_range(0, 2) != 0));
         src_data_i  = (m_cnt < total) ? beats[m_cnt] : rand_word();
         m_tready_i  = (rmode == 0) ? 1'b1 : (rmode == 1) ? ~m_tready_i : 1'($urandom_range(0, 1));
         s_tvalid_i  = (start_cyc >= 0) && (res_sent < nres) && ($urandom_range(0, 1) == 1);
         s_tdata_i   = rand_word();
         s_tlast_i   = (res_sent == nres - 1);
         ap_done_i   = 1'b0;
         if (!no_done && (start_cyc >= 0) && !done_fired && (res_sent == nres)
             && ((m_cnt == total) || (early && (m_cnt == total - 1)))) begin
            ap_done_i  = 1'b1;
            done_fired = 1'b1;
         end
      end

      check("sts_seen", got_sts, 1);
      check("start_pulses", starts, (qry == 0) ? 0 : 1);
      check("m_beats", m_cnt, total);
      check("sts_err", sts_err_o, (qry == 0));
      check("sts_timeout", sts_timeout_o, expect_to);
      check("sts_result_beats", sts_result_beats_o, (qry == 0) ? 0 : nres);
      if (qry == 0) check("err_latency", (cyc - acc_cyc) <= 2, 1);
      else if (!expect_to) check("sts_cycles", sts_cycles_o, CW'(done_cyc - start_cyc));
      held = sts_result_beats_o;

      @(posedge clk_i); #1;
      src_valid_i = 1'b0; s_tvalid_i = 1'b0; ap_done_i = 1'b0;
      @(negedge clk_i);
      check("sts_single_pulse", sts_valid_o, 0);
      check("sts_hold", sts_result_beats_o, held);
      if (qry != 0) last_hash_m = expect_to ? 32'h0 : hash;
   endtask

   initial begin
      rst_i = 1'b1;
      cmd_valid_i = 1'b0; cmd_nfa_hash_i = '0; cmd_nfa_beats_i = '0; cmd_query_beats_i = '0;
      src_valid_i = 1'b0; src_data_i = '0; ap_done_i = 1'b0; m_tready_i = 1'b0;
      s_tvalid_i = 1'b0; s_tdata_i = '0; s_tlast_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_cmd_ready", cmd_ready_o, 0);
      check("rst_ap_start", ap_start_o, 0);
      check("rst_m_tvalid", m_tvalid_o, 0);
      check("rst_s_tready", s_tready_o, 0);
      check("rst_sts_valid", sts_valid_o, 0);
      check("rst_nfa_hash", nfa_hash_o, 0);
      check("rst_m_tkeep", m_tkeep_o, {(DW/8){1'b1}});
      @(posedge clk_i); #1 rst_i = 1'b0;

      // Hash 0 right after reset matches the reset hash: NFA skipped.
      run_job(32'h0, 5, 1, 1, 0, 0, 1'b0, 1'b0, 1'b0);
      // New hash: NFA 4 + query 3, two results.
      run_job(32'hA5, 4, 3, 2, 0, 0, 1'b0, 1'b0, 1'b0);
      // Same hash: query only.
      run_job(32'hA5, 4, 2, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      // Zero-length query is rejected.
      run_job(32'h11, 3, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      // Toggling ready, source gaps, ap_done arriving before the final tlast.
      run_job(32'h3C, 3, 4, 0, 1, 1, 1'b1, 1'b0, 1'b0);
      run_job(32'h3C, 3, 1, 0, 1, 1, 1'b1, 1'b0, 1'b0);
      // Reset clears the remembered hash, forcing a reload of the same image.
      do_reset();
      run_job(32'h3C, 2, 2, 1, 0, 0, 1'b0, 1'b0, 1'b0);

      for (int j = 0; j < 10; j++) begin
         logic [31:0] h;
         h = ($urandom_range(0, 2) == 0) ? 32'hA5 : ($urandom_range(0, 1) == 0) ? 32'h3C : 32'h0;
         run_job(h, $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 3),
                 $urandom_range(0, 2), $urandom_range(0, 1), 1'($urandom_range(0, 1)),
                 1'b0, 1'b0);
      end

`ifdef ERBIUM_DRV_TIMEOUT_EN
      // Kernel never finishes: watchdog aborts, then the same hash reloads its NFA.
      run_job(32'h77, 2, 2, 0, 0, 0, 1'b0, 1'b1, 1'b1);
      run_job(32'h77, 2, 1, 0, 0, 0, 1'b0, 1'b0, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/erbium_stream_driver.md
Name: erbium_stream_driver

Overview:
- On-chip initiator for the ERBium kernel's control and stream protocol; sits upstream of the kernel on the data clock.
- Takes a job command: NFA hash, NFA beat count and query beat count.
- Pulses ap_start and drives the inputs stream: optional NFA segment, then the query segment, each closed by tlast.
- Drains the results stream, waits for ap_done, then reports beat counts and latency. Used for on-board self-test and benchmarking without host DMA.

Parameters:
- DATA_WIDTH, 512, width of source, inputs-stream and results-stream tdata.
- CNT_WIDTH, 32, width of beat counters and the cycle counter.
- TIMEOUT_CYCLES, 65536, watchdog limit in cycles; only used when ERBIUM_DRV_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  data clock.
- rst_i  in  1  reset; synchronous, active-high.
- cmd_valid_i  in  1  job command valid.
- cmd_ready_o  out  1  job command accepted; high only in IDLE.
- cmd_nfa_hash_i  in  32  NFA identity for the job.
- cmd_nfa_beats_i  in  CNT_WIDTH  NFA image length in beats.
- cmd_query_beats_i  in  CNT_WIDTH  query length in beats.
- src_valid_i  in  1  payload source valid (NFA beats first, then query beats).
- src_ready_o  out  1  payload source ready.
- src_data_i  in  DATA_WIDTH  payload beat.
- ap_start_o  out  1  kernel start.
- ap_done_i  in  1  kernel done, one-cycle pulse.
- nfa_hash_o  out  32  hash presented to the kernel; held stable.
- m_tvalid_o  out  1  kernel inputs stream valid.
- m_tready_i  in  1  kernel inputs stream ready.
- m_tdata_o  out  DATA_WIDTH  kernel inputs stream data.
- m_tkeep_o  out  DATA_WIDTH/8  kernel inputs stream keep; all ones.
- m_tlast_o  out  1  kernel inputs stream last.
- s_tvalid_i  in  1  kernel results stream valid.
- s_tready_o  out  1  kernel results stream ready.
- s_tdata_i  in  DATA_WIDTH  kernel results stream data; discarded.
- s_tlast_i  in  1  kernel results stream last.
- sts_valid_o  out  1  one-cycle job-complete pulse.
- sts_err_o  out  1  command rejected (query beats = 0).
- sts_timeout_o  out  1  job aborted by the watchdog.
- sts_result_beats_o  out  CNT_WIDTH  result beats received in the job.
- sts_cycles_o  out  CNT_WIDTH  cycles from the start pulse to ap_done.

Behaviour:
- Reset values: state IDLE; all outputs 0 except m_tkeep_o (all ones); last_hash register 0.
  - last_hash resets to 0, the same as the kernel's hash register, so a first job with hash 0 sends no NFA.
- States: IDLE, START, SEND_NFA, SEND_QRY, WAIT_DONE, REPORT.
- IDLE: cmd_ready_o=1. On cmd_valid_i:
  - Latch the command and clear all counters.
  - If cmd_query_beats_i==0: go to REPORT with err=1, no start issued.
  - Otherwise set reload = (cmd_nfa_hash_i != last_hash) AND (cmd_nfa_beats_i != 0), and go to START.
- START, 1 cycle:
  - ap_start_o=1; nfa_hash_o = latched hash; last_hash updated to latched hash.
  - Next state: SEND_NFA if reload, else SEND_QRY.
  - ap_start_o is 0 in every other state, so the kernel always sees a clean rising edge.
- SEND_NFA / SEND_QRY:
  - m_tvalid_o = src_valid_i; src_ready_o = m_tready_i; m_tdata_o = src_data_i (combinational pass-through).
  - m_tlast_o = 1 when the remaining count == 1.
  - Each m handshake decrements the remaining count.
  - Handshake with tlast: SEND_NFA goes to SEND_QRY; SEND_QRY goes to WAIT_DONE.
  - src_ready_o and m_tvalid_o are 0 in all other states.
- NFA skipped on hash match:
  - cmd_nfa_beats_i is ignored.
  - The source must not present NFA beats; the driver does not consume them.
- Results: s_tready_o=1 in every state except IDLE and REPORT.
  - Handshakes in START..WAIT_DONE increment result_beats; data is ignored.
  - result_beats saturates at all ones.
- ap_done_i:
  - Honoured in SEND_QRY and WAIT_DONE; in SEND_QRY it is latched and acted on after the final tlast.
  - In WAIT_DONE (or once latched): go to REPORT.
  - Pulses arriving in any other state are ignored.
- cycles counter: counts from the cycle after START up to and including the cycle of the ap_done_i pulse; saturates.
- REPORT, 1 cycle: sts_valid_o=1; the sts_* values stay valid and hold until the next command. Then go to IDLE.
- Simultaneous events:
  - Result handshake in the same cycle as ap_done_i: the beat is counted.
  - cmd_valid_i in REPORT: ignored until IDLE.
- Reset mid-job: return to IDLE the next cycle; last_hash returns to 0. The kernel must be reset alongside.

Optional Feature:
- Macro: ERBIUM_DRV_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on any m or s handshake and on state entry, and increments in SEND_NFA, SEND_QRY and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES: go to REPORT with sts_timeout_o=1 and clear last_hash to 0, forcing an NFA reload on the next job.
- Not defined: no watchdog logic; sts_timeout_o tied to 0.

Test Plan:
- Reset, then hash 0xA5, nfa 4, query 3, kernel model ready, 2 result beats then ap_done → one ap_start pulse; 7 m beats with tlast on beats 4 and 7; sts_result_beats=2; sts_valid single pulse.
- Repeat hash 0xA5 with nfa 4, query 2 → no NFA beats; 2 m beats, tlast on beat 2.
- Hash 0 as the first job after reset with nfa 5, query 1 → NFA skipped; 1 beat with tlast.
- query_beats=0 → no ap_start; sts_err=1 and sts_valid pulse within 2 cycles of the command.
- m_tready_i toggling 1/0 every cycle plus src_valid_i gaps → no beat duplicated or lost; tlast only on the final beat; ap_done arriving during SEND_QRY is honoured after tlast.
- With ERBIUM_DRV_TIMEOUT_EN and TIMEOUT_CYCLES=16, ap_done never asserted → sts_timeout=1 after 16 idle cycles in WAIT_DONE; the next job with the same hash resends the NFA.
